uart_alu_interface: RTL and testbench

Frame assembler between the UART receiver and the ALU/transmitter pair. Consumes the receiver's byte strobe and data, collects a three-byte command (operand A, operand B, opcode), drives the ALU, and hands the registered result to the UART transmitter with a start/done handshake. An inter-byte timeout discards incomplete frames. An overrun flag reports bytes that arrive while a result is still being sent.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/frame_timeout_counter.sv | 33 +++
 rtl/uart_alu_interface.sv | 118 +++++++++++
 tb/tb_uart_alu_interface.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU frame assembler: default widths,
// the state encoding and the ALU opcode values.
package uart_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int NB_OP_DEFAULT   = 6;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_LOAD    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count sits at TIMEOUT-1. TIMEOUT of 0 never expires.
module frame_timeout_counter #(
  parameter int                    NB_TIMEOUT = 20,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT    = 20'd868000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [NB_TIMEOUT-1:0] LAST = TIMEOUT - NB_TIMEOUT'(1);

  logic [NB_TIMEOUT-1:0] count;

  // A clear in the same cycle (an accepted byte) suppresses expiry.
  assign expired = (TIMEOUT != '0) && enable && !clear && (count == LAST);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable || expired) begin
      count <= '0;
    end else begin
      count <= count + NB_TIMEOUT'(1);
    end
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B and opcode bytes from the UART receiver, drives the ALU and
// hands the registered result to the transmitter with a start/done handshake.
module uart_alu_interface
  import uart_pkg::*;
#(
  parameter int                    NB_DATA    = NB_DATA_DEFAULT,
  parameter int                    NB_OP      = NB_OP_DEFAULT,
  parameter int                    NB_TIMEOUT = 20,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT    = 20'd868000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  state_t state, state_next;
  logic   accept_a, accept_b, accept_op;
  logic   overrun, timeout_hit, expired;
  logic   in_frame;

  assign in_frame = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
  assign o_busy   = (state != ST_WAIT_A);

  frame_timeout_counter #(
    .NB_TIMEOUT (NB_TIMEOUT),
    .TIMEOUT    (TIMEOUT)
  ) u_timeout (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .clear   (accept_a | accept_b | accept_op),
    .enable  (in_frame),
    .expired (expired)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= ST_WAIT_A;
    else          state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    accept_a    = 1'b0;
    accept_b    = 1'b0;
    accept_op   = 1'b0;
    overrun     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_WAIT_A: begin
        if (i_rx_done_tick) begin
          accept_a   = 1'b1;
          state_next = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done_tick) begin
          accept_b   = 1'b1;
          state_next = ST_WAIT_OP;
        end else if (expired) begin
          timeout_hit = 1'b1;
          state_next  = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done_tick) begin
          accept_op  = 1'b1;
          state_next = ST_LOAD;
        end else if (expired) begin
          timeout_hit = 1'b1;
          state_next  = ST_WAIT_A;
        end
      end
      ST_LOAD: begin
        overrun    = i_rx_done_tick;
        state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // A byte coincident with tx_done is still dropped as an overrun.
        overrun = i_rx_done_tick;
        if (i_tx_done_tick) state_next = ST_WAIT_A;
      end
      default: state_next = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_tx_start <= (state == ST_LOAD);
      o_timeout  <= timeout_hit;
      o_overrun  <= overrun;
      if (accept_a)           o_data_a  <= i_rx_data;
      if (accept_b)           o_data_b  <= i_rx_data;
      if (accept_op)          o_op      <= i_rx_data[NB_OP-1:0];
      if (state == ST_LOAD)   o_tx_data <= i_alu_result;
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench: directed frames push expected tx/timeout/overrun events;
// a negedge monitor pops and compares whenever the DUT pulses one.
module tb_uart_alu_interface;
  import uart_pkg::*;

  localparam int                    NB_DATA    = 8;
  localparam int                    NB_OP      = 6;
  localparam int                    NB_TIMEOUT = 20;
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT    = 20'd50;
  localparam int                    TO         = 50;

  logic               clock   = 1'b0;
  logic               reset_n = 1'b0;
  logic               rx_tick = 1'b0;
  logic               tx_done = 1'b0;
  logic [NB_DATA-1:0] rx_data = '0;
  logic [NB_DATA-1:0] alu_result, data_a, data_b, tx_data;
  logic [NB_OP-1:0]   op;
  logic               tx_start, busy, timeout, overrun;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] tx_q[$];
  logic [7:0] to_q[$];
  logic [7:0] ov_q[$];

  always #5 clock = ~clock;

  uart_alu_interface #(
    .NB_DATA    (NB_DATA),
    .NB_OP      (NB_OP),
    .NB_TIMEOUT (NB_TIMEOUT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .i_clock        (clock),
    .i_reset        (reset_n),
    .i_rx_done_tick (rx_tick),
    .i_rx_data      (rx_data),
    .i_alu_result   (alu_result),
    .i_tx_done_tick (tx_done),
    .o_data_a       (data_a),
    .o_data_b       (data_b),
    .o_op           (op),
    .o_tx_data      (tx_data),
    .o_tx_start     (tx_start),
    .o_busy         (busy),
    .o_timeout      (timeout),
    .o_overrun      (overrun)
  );

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD: alu_result = data_a + data_b;
      OP_SUB: alu_result = data_a - data_b;
      OP_AND: alu_result = data_a & data_b;
      OP_OR:  alu_result = data_a | data_b;
      OP_XOR: alu_result = data_a ^ data_b;
      OP_SRA: alu_result = 8'($signed(data_a) >>> data_b[2:0]);
      OP_SRL: alu_result = data_a >> data_b[2:0];
      OP_NOR: alu_result = ~(data_a | data_b);
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_tick = 1'b1;
    @(negedge clock);
    rx_tick = 1'b0;
  endtask

  task automatic tx_finish();
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},       32'(data_a),   0);
    check({tag, "_b"},       32'(data_b),   0);
    check({tag, "_op"},      32'(op),       0);
    check({tag, "_tx_data"}, 32'(tx_data),  0);
    check({tag, "_pulses"},  32'({tx_start, timeout, overrun}), 0);
    check({tag, "_busy"},    32'(busy),     0);
  endtask

  // Monitor: every pulse must match a queued expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (tx_start) begin
        check("tx_start_expected", 32'(tx_q.size() != 0), 1);
        if (tx_q.size() != 0) check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
      end
      if (timeout) begin
        check("timeout_expected", 32'(to_q.size() != 0), 1);
        if (to_q.size() != 0) check("timeout_data_a", 32'(data_a), 32'(to_q.pop_front()));
      end
      if (overrun) begin
        check("overrun_expected", 32'(ov_q.size() != 0), 1);
        if (ov_q.size() != 0) check("overrun_data_a", 32'(data_a), 32'(ov_q.pop_front()));
      end
    end
  end

  initial begin
    idle(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    idle(1);

    // Normal frame: 5 + 3 = 8, start pulse two cycles after the opcode tick.
    send(8'h05);
    check("a_loaded", 32'(data_a), 32'h05);
    check("busy_after_a", 32'(busy), 1);
    send(8'h03);
    check("b_loaded", 32'(data_b), 32'h03);
    tx_q.push_back(8'h08);
    send(8'h20);
    check("op_in_load", 32'(op), 32'h20);
    check("no_start_in_load", 32'(tx_start), 0);
    idle(1);
    check("start_at_n2", 32'(tx_start), 1);
    idle(1);
    check("start_cleared", 32'(tx_start), 0);
    idle(3);
    check("busy_wait_tx", 32'(busy), 1);
    tx_finish();
    check("busy_after_done", 32'(busy), 0);

    // Timeout: A then 50 idle cycles.
    to_q.push_back(8'hAA);
    send(8'hAA);
    idle(TO - 1);
    check("no_early_timeout", 32'(timeout), 0);
    check("busy_before_timeout", 32'(busy), 1);
    idle(1);
    check("timeout_pulse", 32'(timeout), 1);
    check("idle_after_timeout", 32'(busy), 0);
    check("b_kept_after_timeout", 32'(data_b), 32'h03);
    idle(1);
    check("timeout_single", 32'(timeout), 0);
    tx_q.push_back(8'hFF);
    send(8'h01);
    send(8'h02);
    send(8'h22);
    idle(3);
    tx_finish();

    // Expiry race: B arrives in the cycle the counter would expire.
    send(8'h11);
    idle(TO - 1);
    send(8'h22);
    check("race_b_accepted", 32'(data_b), 32'h22);
    check("race_no_timeout", 32'(timeout), 0);
    check("race_busy", 32'(busy), 1);
    tx_q.push_back(8'h33);
    send(8'h20);
    idle(3);
    tx_finish();

    // Overrun in WAIT_TX and coincident with tx_done.
    tx_q.push_back(8'h0B);
    send(8'h07);
    send(8'h04);
    send(8'h20);
    idle(2);
    ov_q.push_back(8'h07);
    send(8'h99);
    check("overrun_pulse_1", 32'(overrun), 1);
    idle(2);
    ov_q.push_back(8'h07);
    rx_data = 8'h55;
    rx_tick = 1'b1;
    tx_done = 1'b1;
    @(negedge clock);
    rx_tick = 1'b0;
    tx_done = 1'b0;
    check("overrun_pulse_2", 32'(overrun), 1);
    check("idle_after_coincident", 32'(busy), 0);
    check("a_after_overrun", 32'(data_a), 32'h07);
    idle(1);
    check("overrun_cleared", 32'(overrun), 0);

    // Reset mid-frame, then a fresh frame with a masked opcode.
    send(8'h3C);
    send(8'h4D);
    reset_n = 1'b0;
    idle(3);
    check_all_zero("midreset");
    reset_n = 1'b1;
    idle(1);
    tx_q.push_back(8'hFF);
    send(8'h0F);
    send(8'hF0);
    send(8'hE5);
    check("op_masked", 32'(op), 32'h25);
    idle(3);
    tx_finish();

    // Back-to-back: A accepted in the cycle right after tx_done.
    send(8'h40);
    check("b2b_a", 32'(data_a), 32'h40);
    tx_q.push_back(8'h01);
    send(8'h41);
    send(8'h26);
    idle(3);
    tx_finish();
    idle(5);

    check("tx_q_drained", 32'(tx_q.size()), 0);
    check("to_q_drained", 32'(to_q.size()), 0);
    check("ov_q_drained", 32'(ov_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
